kd_tree_root_ctrl: RTL

- Sequencer above the kd-tree root node; it is the root node's "top" neighbour.
- Runs one job per `start` pulse:
  - broadcasts depth/axis configuration and collects the tree-wide sort ack;
  - issues sort passes until the tree reports no swaps;
  - streams `num_points` points into the tree one at a time under a command/ack handshake.
- Reports `done` or `error` to the host-side datapath.

---
 rtl/kd_tree_pkg.sv | 32 +++
 rtl/kd_tree_root_ctrl_if.sv | 33 +++
 rtl/kd_wait_timer.sv | 41 ++++
 rtl/kd_tree_root_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/kd_tree_pkg.sv
// Shared kd-tree definitions: node command codes, root-controller states and
// the config-word field layout used by both the root controller and the nodes.
package kd_tree_pkg;

  localparam int unsigned CMD_W       = 3;
  localparam int unsigned PASS_W      = 5;
  // time_to_live field of the config word starts at this bit
  localparam int unsigned CFG_TTL_LSB = 0;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP        = 3'd0,
    CMD_CONFIG     = 3'd1,
    CMD_START_SORT = 3'd2,
    CMD_SORT_ACK   = 3'd3,
    CMD_SORT_DONE  = 3'd4,
    CMD_POINT      = 3'd5,
    CMD_POINT_ACK  = 3'd6,
    CMD_ABORT      = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_CFG   = 3'd1,
    ST_WAIT_SORT  = 3'd2,
    ST_RESORT     = 3'd3,
    ST_POINT_SEND = 3'd4,
    ST_WAIT_PT    = 3'd5,
    ST_FINISH     = 3'd6,
    ST_ERR        = 3'd7
  } state_e;

endpackage

// File: rtl/kd_tree_root_ctrl_if.sv
// Host and root-node signals of the kd-tree root controller.
// master = host/root side, slave = controller side.
interface kd_tree_root_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NPTS_W = 16
);
  import kd_tree_pkg::*;

  logic              start;
  logic [NPTS_W-1:0] num_points;
  logic [DATA_W-1:0] point_in;
  logic              point_valid;
  logic              point_ready;
  logic [CMD_W-1:0]  cmd_to_root;
  logic [DATA_W-1:0] data_to_root;
  logic [CMD_W-1:0]  cmd_from_root;
  logic [DATA_W-1:0] data_from_root;
  logic              busy;
  logic              done;
  logic              error;
  logic [PASS_W-1:0] pass_count;

  modport master (
    output start, num_points, point_in, point_valid, cmd_from_root, data_from_root,
    input  point_ready, cmd_to_root, data_to_root, busy, done, error, pass_count
  );

  modport slave (
    input  start, num_points, point_in, point_valid, cmd_from_root, data_from_root,
    output point_ready, cmd_to_root, data_to_root, busy, done, error, pass_count
  );

endinterface

// File: rtl/kd_wait_timer.sv
// Wait-state watchdog: cleared by load_i, counts while en_i, and flags
// expire_o during the cycle the count sits at TIMEOUT-1.
module kd_wait_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q;

  // saturate at LAST so a stalled wait keeps reporting expiry
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= (cnt_d == LAST);
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/kd_tree_root_ctrl.sv
// kd-tree root sequencer: configures the tree, runs sort passes until no swaps,
// then streams the host's points into the root node one at a time.
module kd_tree_root_ctrl
  import kd_tree_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_W    = 4,
  parameter int unsigned TREE_DEPTH = 3,
  parameter int unsigned NPTS_W     = 16,
  parameter int unsigned MAX_PASSES = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic              clk,
  input logic              rst,
  kd_tree_root_ctrl_if.slave bus
);

  localparam logic [DATA_W-1:0] CFG_WORD =
    DATA_W'(DEPTH_W'(TREE_DEPTH)) << CFG_TTL_LSB;
  localparam logic [PASS_W-1:0] PASS_LIMIT = PASS_W'(MAX_PASSES);

  state_e            state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [NPTS_W-1:0] remain_q, remain_d;

  logic tmr_load, tmr_en, tmr_expire;
  logic swap;
  logic unused_data_hi;

  assign swap           = bus.data_from_root[0];
  assign unused_data_hi = ^bus.data_from_root[DATA_W-1:1];

  kd_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  // next-state and registered-output values; commands are held as levels
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    error_d  = error_q;
    pass_d   = pass_q;
    remain_d = remain_q;

    unique case (state_q)
      ST_IDLE: begin
        cmd_d = CMD_NOP;
        if (bus.start) begin
          state_d  = ST_WAIT_CFG;
          cmd_d    = CMD_CONFIG;
          data_d   = CFG_WORD;
          error_d  = 1'b0;
          pass_d   = '0;
          remain_d = bus.num_points;
        end
      end

      ST_WAIT_CFG: begin
        if (bus.cmd_from_root == CMD_SORT_ACK) begin
          state_d = ST_WAIT_SORT;
          cmd_d   = CMD_START_SORT;
          pass_d  = pass_q + PASS_W'(1);
        end else if (tmr_expire) begin
          state_d = ST_ERR;
          cmd_d   = CMD_ABORT;
          error_d = 1'b1;
        end
      end

      ST_WAIT_SORT: begin
        if (bus.cmd_from_root == CMD_SORT_DONE) begin
          if (!swap) begin
            cmd_d   = CMD_NOP;
            state_d = (remain_q == '0) ? ST_FINISH : ST_POINT_SEND;
          end else if (pass_q < PASS_LIMIT) begin
            cmd_d   = CMD_NOP;
            state_d = ST_RESORT;
          end else begin
            state_d = ST_ERR;
            cmd_d   = CMD_ABORT;
            error_d = 1'b1;
          end
        end else if (tmr_expire) begin
          state_d = ST_ERR;
          cmd_d   = CMD_ABORT;
          error_d = 1'b1;
        end
      end

      // single NOP cycle so the tree sees a fresh START_SORT level
      ST_RESORT: begin
        state_d = ST_WAIT_SORT;
        cmd_d   = CMD_START_SORT;
        pass_d  = pass_q + PASS_W'(1);
      end

      ST_POINT_SEND: begin
        if (bus.point_valid) begin
          state_d = ST_WAIT_PT;
          cmd_d   = CMD_POINT;
          data_d  = bus.point_in;
        end
      end

      ST_WAIT_PT: begin
        if (bus.cmd_from_root == CMD_POINT_ACK) begin
          cmd_d    = CMD_NOP;
          remain_d = remain_q - NPTS_W'(1);
          state_d  = (remain_q == NPTS_W'(1)) ? ST_FINISH : ST_POINT_SEND;
        end else if (tmr_expire) begin
          state_d = ST_ERR;
          cmd_d   = CMD_ABORT;
          error_d = 1'b1;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        cmd_d   = CMD_NOP;
      end

      ST_ERR: begin
        state_d = ST_IDLE;
        cmd_d   = CMD_NOP;
      end

      default: begin
        state_d = ST_IDLE;
        cmd_d   = CMD_NOP;
      end
    endcase

    ready_d  = (state_d == ST_POINT_SEND);
    busy_d   = !(state_d inside {ST_IDLE, ST_FINISH});
    done_d   = (state_d == ST_FINISH);
    tmr_load = (state_d != state_q);
    tmr_en   = (state_q inside {ST_WAIT_CFG, ST_WAIT_SORT, ST_WAIT_PT});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_NOP;
      data_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      pass_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      pass_q   <= pass_d;
      remain_q <= remain_d;
    end
  end

  assign bus.cmd_to_root  = cmd_q;
  assign bus.data_to_root = data_q;
  assign bus.point_ready  = ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.pass_count   = pass_q;

endmodule
